// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token codes, the alignment state type and token lookups.
package tmds_pkg;

  localparam logic [9:0] TokCtrl00 = 10'b1101010100;
  localparam logic [9:0] TokCtrl01 = 10'b0010101011;
  localparam logic [9:0] TokCtrl10 = 10'b0101010100;
  localparam logic [9:0] TokCtrl11 = 10'b1010101011;

  typedef enum logic [1:0] {
    StSearch = 2'd0,
    StVerify = 2'd1,
    StLocked = 2'd2
  } state_e;

  function automatic logic is_token(input logic [9:0] sym);
    return (sym == TokCtrl00) || (sym == TokCtrl01) ||
           (sym == TokCtrl10) || (sym == TokCtrl11);
  endfunction

  // Non-token symbols map to 2'b00; callers qualify with is_token().
  function automatic logic [1:0] token_ctrl(input logic [9:0] sym);
    logic [1:0] c;
    c = 2'b00;
    unique case (sym)
      TokCtrl01: c = 2'b01;
      TokCtrl10: c = 2'b10;
      TokCtrl11: c = 2'b11;
      default:   c = 2'b00;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational decode of one aligned 10-bit TMDS symbol into token/control or pixel data.
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [9:0] sym_i,
  output logic       is_token_o,
  output logic [1:0] ctrl_o,
  output logic [7:0] data_o
);

  logic [7:0] q_inv;

  always_comb begin
    q_inv     = sym_i[9] ? ~sym_i[7:0] : sym_i[7:0];
    data_o    = '0;
    data_o[0] = q_inv[0];
    // Bit 8 selects XOR versus XNOR chaining on the encode side.
    for (int i = 1; i < 8; i++) begin
      data_o[i] = sym_i[8] ? (q_inv[i] ^ q_inv[i-1]) : ~(q_inv[i] ^ q_inv[i-1]);
    end
  end

  assign is_token_o = is_token(sym_i);
  assign ctrl_o     = token_ctrl(sym_i);

endmodule

// File: rtl/tmds_channel_rx.sv
// TMDS channel receiver: hunts control tokens for symbol alignment, locks, then decodes symbols.
module tmds_channel_rx
  import tmds_pkg::*;
#(
  parameter int unsigned LOCK_COUNT   = 16,
  parameter int unsigned LOSS_TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [9:0] raw_word,
  output logic       out_valid,
  output logic       de,
  output logic [7:0] data,
  output logic [1:0] ctrl,
  output logic       locked,
  output logic [3:0] offset
);

  localparam int unsigned CntW  = $clog2(LOCK_COUNT + 1);
  localparam int unsigned IdleW = $clog2(LOSS_TIMEOUT + 1);
  localparam logic [CntW-1:0]  CntMax  = CntW'(LOCK_COUNT);
  localparam logic [IdleW-1:0] IdleMax = IdleW'(LOSS_TIMEOUT);

  state_e           state_q, state_d;
  logic [9:0]       prev_q, prev_d;
  logic [3:0]       offset_q, offset_d;
  logic [CntW-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [IdleW-1:0] idle_q, idle_d, idle_inc;
  logic             out_valid_q, out_valid_d;
  logic             de_q, de_d;
  logic [7:0]       data_q, data_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic             locked_q, locked_d;

  logic [19:0] window;
  logic [9:0]  cand [10];
  logic [9:0]  hit_vec;
  logic [3:0]  first_k;
  logic [9:0]  sym;
  logic        sym_is_tok;
  logic [1:0]  sym_ctrl;
  logic [7:0]  sym_data;

  assign window = {raw_word, prev_q};

  for (genvar k = 0; k < 10; k++) begin : g_scan
    assign cand[k]    = window[k +: 10];
    assign hit_vec[k] = is_token(cand[k]);
  end

  // Descending scan so the lowest matching offset wins.
  always_comb begin
    first_k = '0;
    for (int k = 9; k >= 0; k--) begin
      if (hit_vec[k]) first_k = 4'(k);
    end
  end

  assign sym = cand[offset_q];

  tmds_symbol_decode u_dec (
    .sym_i     (sym),
    .is_token_o(sym_is_tok),
    .ctrl_o    (sym_ctrl),
    .data_o    (sym_data)
  );

  assign cnt_inc  = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
  assign idle_inc = (idle_q == IdleMax) ? idle_q : idle_q + IdleW'(1);

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    offset_d    = offset_q;
    cnt_d       = cnt_q;
    idle_d      = idle_q;
    de_d        = de_q;
    data_d      = data_q;
    ctrl_d      = ctrl_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      prev_d = raw_word;
      if (sym_is_tok) begin
        de_d   = 1'b0;
        data_d = '0;
        ctrl_d = sym_ctrl;
      end else begin
        de_d   = 1'b1;
        data_d = sym_data;
      end
      unique case (state_q)
        StSearch: begin
          if (|hit_vec) begin
            state_d  = StVerify;
            offset_d = first_k;
            cnt_d    = CntW'(1);
          end
        end
        StVerify: begin
          if (sym_is_tok) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CntMax) state_d = StLocked;
          end else begin
            state_d = StSearch;
            cnt_d   = '0;
          end
        end
        StLocked: begin
          if (sym_is_tok) begin
            idle_d = '0;
          end else begin
            idle_d = idle_inc;
            if (idle_inc == IdleMax) begin
              state_d = StSearch;
              cnt_d   = '0;
              idle_d  = '0;
            end
          end
        end
        default: state_d = StSearch;
      endcase
      out_valid_d = (state_d == StLocked);
    end
    locked_d = (state_d == StLocked);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StSearch;
      prev_q      <= '0;
      offset_q    <= '0;
      cnt_q       <= '0;
      idle_q      <= '0;
      out_valid_q <= 1'b0;
      de_q        <= 1'b0;
      data_q      <= '0;
      ctrl_q      <= '0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      offset_q    <= offset_d;
      cnt_q       <= cnt_d;
      idle_q      <= idle_d;
      out_valid_q <= out_valid_d;
      de_q        <= de_d;
      data_q      <= data_d;
      ctrl_q      <= ctrl_d;
      locked_q    <= locked_d;
    end
  end

  assign out_valid = out_valid_q;
  assign de        = de_q;
  assign data      = data_q;
  assign ctrl      = ctrl_q;
  assign locked    = locked_q;
  assign offset    = offset_q;

endmodule

// File: tb/tb_tmds_channel_rx.sv
// Directed plus randomized bench for tmds_channel_rx against a behavioural channel model.
module tb_tmds_channel_rx;

  localparam int LockCount   = 16;
  localparam int LossTimeout = 4096;
  localparam logic [9:0] T00    = 10'b1101010100;
  localparam logic [9:0] T01    = 10'b0010101011;
  localparam logic [9:0] T10    = 10'b0101010100;
  localparam logic [9:0] T11    = 10'b1010101011;
  localparam logic [9:0] DataEf = 10'b1011110000;
  localparam logic [9:0] Data10 = 10'b0111110000;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [9:0] raw_word;
  logic       out_valid;
  logic       de;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic       locked;
  logic [3:0] offset;

  tmds_channel_rx #(
    .LOCK_COUNT  (LockCount),
    .LOSS_TIMEOUT(LossTimeout)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .raw_word (raw_word),
    .out_valid(out_valid),
    .de       (de),
    .data     (data),
    .ctrl     (ctrl),
    .locked   (locked),
    .offset   (offset)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model: mode 0 hunting, 1 confirming, 2 locked.
  int         m_mode;
  logic [9:0] m_prev;
  int         m_off;
  int         m_cnt;
  int         m_idle;
  logic       m_ov;
  logic       m_de;
  logic [7:0] m_data;
  logic [1:0] m_ctrl;
  logic       m_locked;

  function automatic int tok_code(input logic [9:0] s);
    if (s == T00) return 0;
    if (s == T01) return 1;
    if (s == T10) return 2;
    if (s == T11) return 3;
    return -1;
  endfunction

  function automatic logic [7:0] ref_data(input logic [9:0] q);
    logic [7:0] p;
    logic [7:0] d;
    p    = q[9] ? ~q[7:0] : q[7:0];
    d    = '0;
    d[0] = p[0];
    for (int i = 1; i < 8; i++) d[i] = ((p[i] != p[i-1]) == q[8]);
    return d;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_prev = '0; m_off = 0; m_cnt = 0; m_idle = 0;
    m_ov = 1'b0; m_de = 1'b0; m_data = '0; m_ctrl = '0; m_locked = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [9:0] w);
    logic [19:0] win;
    logic [9:0]  s;
    int          t;
    if (!v) begin
      m_ov = 1'b0;
      return;
    end
    win = {w, m_prev};
    s   = win[m_off +: 10];
    t   = tok_code(s);
    if (t >= 0) begin
      m_de = 1'b0; m_data = '0; m_ctrl = 2'(t);
    end else begin
      m_de = 1'b1; m_data = ref_data(s);
    end
    if (m_mode == 0) begin
      for (int k = 9; k >= 0; k--) begin
        if (tok_code(win[k +: 10]) >= 0) begin
          m_mode = 1; m_off = k; m_cnt = 1;
        end
      end
    end else if (m_mode == 1) begin
      if (t >= 0) begin
        m_cnt++;
        if (m_cnt >= LockCount) m_mode = 2;
      end else begin
        m_mode = 0; m_cnt = 0;
      end
    end else begin
      if (t >= 0) m_idle = 0;
      else begin
        m_idle++;
        if (m_idle >= LossTimeout) begin
          m_mode = 0; m_idle = 0; m_cnt = 0;
        end
      end
    end
    m_prev   = w;
    m_locked = (m_mode == 2);
    m_ov     = m_locked;
  endtask

  task automatic check_all(input string tag);
    logic [16:0] obs;
    logic [16:0] exp;
    obs = {out_valid, de, data, ctrl, locked, offset};
    exp = {m_ov, m_de, m_data, m_ctrl, m_locked, 4'(m_off)};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic v, input logic [9:0] w, input string tag);
    in_valid = v;
    raw_word = w;
    @(posedge clk);
    #1;
    model_step(v, w);
    check_all(tag);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b1;
    raw_word = T00;
    @(posedge clk);
    #1;
    model_reset();
    check_all("reset");
    check_val("reset_outs", 16'({out_valid, de, data, ctrl, locked, offset}), 16'd0);
    reset = 1'b0;
  endtask

  function automatic logic [9:0] rand_data_word();
    logic [9:0] w;
    w = 10'($urandom);
    while (tok_code(w) >= 0) w = 10'($urandom);
    return w;
  endfunction

  initial begin
    logic [9:0] rot_word;
    logic [9:0] sym00;
    int         gaps;
    int         cyc;
    int         first_lock;

    reset = 1'b1; in_valid = 1'b0; raw_word = '0;
    model_reset();

    // Aligned lock: not yet after 16 tokens, locked on the 17th.
    do_reset();
    for (int i = 1; i <= 16; i++) apply(1'b1, T00, "aligned_acq");
    check_val("aligned_16_unlocked", 16'(locked), 16'd0);
    apply(1'b1, T00, "aligned_17");
    check_val("aligned_17_locked", 16'({locked, out_valid, de, ctrl, offset}), 16'b11_0_00_0000);

    // At offset 0 each symbol appears one word after it is sent.
    apply(1'b1, DataEf, "dec_a");
    apply(1'b1, Data10, "dec_b");
    check_val("dec_ef", 16'({de, data}), 16'h1EF);
    apply(1'b1, T01, "dec_c");
    check_val("dec_10", 16'({de, data}), 16'h110);
    apply(1'b1, T10, "dec_d");
    check_val("dec_ctrl01", 16'({de, ctrl}), 16'b0_01);
    apply(1'b1, T11, "dec_e");
    check_val("dec_ctrl10", 16'({de, ctrl}), 16'b0_10);
    apply(1'b1, DataEf, "dec_f");
    check_val("dec_ctrl11", 16'({de, ctrl}), 16'b0_11);
    apply(1'b1, DataEf, "dec_g");
    check_val("ctrl_held", 16'({de, ctrl}), 16'b1_11);

    for (int i = 0; i < 300; i++) apply(1'($urandom_range(0, 4) != 0), 10'($urandom), "random");

    // Break during confirmation forces a full restart of the count.
    do_reset();
    for (int i = 0; i < 8; i++) apply(1'b1, T00, "verify_pre");
    apply(1'b1, DataEf, "verify_break");
    for (int i = 1; i <= 16; i++) apply(1'b1, T00, "verify_post");
    check_val("verify_restart_unlocked", 16'(locked), 16'd0);
    apply(1'b1, T00, "verify_post17");
    check_val("verify_restart_locked", 16'(locked), 16'd1);

    // Random in_valid gaps delay the lock edge by exactly the gap count.
    do_reset();
    gaps = 0; cyc = 0; first_lock = 0;
    for (int i = 1; i <= 17; i++) begin
      int g;
      g = int'($urandom_range(0, 3));
      for (int j = 0; j < g; j++) begin
        apply(1'b0, 10'($urandom), "gap_idle");
        cyc++; gaps++;
        if (locked === 1'b1 && first_lock == 0) first_lock = cyc;
      end
      apply(1'b1, T00, "gap_tok");
      cyc++;
      if (locked === 1'b1 && first_lock == 0) first_lock = cyc;
    end
    check_val("gap_lock_cycle", 16'(first_lock), 16'(17 + gaps));

    // Loss of lock: the first data word still shows the last token.
    do_reset();
    for (int i = 0; i < 17; i++) apply(1'b1, T00, "loss_acq");
    for (int k = 1; k <= 4096; k++) apply(1'b1, rand_data_word(), "loss_run");
    check_val("loss_4095_locked", 16'({locked, out_valid}), 16'b11);
    apply(1'b1, rand_data_word(), "loss_drop");
    check_val("loss_4096_dropped", 16'({locked, out_valid}), 16'b00);

    // A single token restarts the idle count.
    do_reset();
    for (int i = 0; i < 17; i++) apply(1'b1, T00, "idle_acq");
    for (int i = 0; i < 2000; i++) apply(1'b1, rand_data_word(), "idle_pre");
    apply(1'b1, T10, "idle_tok");
    for (int m = 1; m <= 3000; m++) apply(1'b1, rand_data_word(), "idle_post");
    check_val("idle_restart_locked", 16'(locked), 16'd1);
    for (int m = 3001; m <= 4096; m++) apply(1'b1, rand_data_word(), "idle_tail");
    check_val("idle_tail_locked", 16'(locked), 16'd1);
    apply(1'b1, rand_data_word(), "idle_drop");
    check_val("idle_dropped", 16'(locked), 16'd0);

    // Reset while locked, then a full fresh acquisition.
    do_reset();
    for (int i = 0; i < 17; i++) apply(1'b1, T00, "rst_acq");
    check_val("rst_pre_locked", 16'(locked), 16'd1);
    do_reset();
    for (int i = 1; i <= 16; i++) apply(1'b1, T00, "rst_reacq");
    check_val("rst_reacq_16", 16'(locked), 16'd0);
    apply(1'b1, T00, "rst_reacq17");
    check_val("rst_reacq_17", 16'(locked), 16'd1);

    // Misaligned stream: token rotated so it lands at offset 3.
    do_reset();
    sym00    = T00;
    rot_word = {sym00[6:0], sym00[9:7]};
    for (int i = 1; i <= 16; i++) apply(1'b1, rot_word, "mis_acq");
    check_val("mis_16_unlocked", 16'(locked), 16'd0);
    apply(1'b1, rot_word, "mis_17");
    check_val("mis_17_locked", 16'({locked, de, ctrl, offset}), 16'b1_0_00_0011);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
